controle_sequenciador_ula: RTL and testbench

Sequencer for the 8-bit ALU's register datapath. It accepts an operation request, collects one or two operands over a valid/ready handshake, and drives them onto a shared bus with one-cycle load strobes for operand registers A and B. It then waits a programmable settle time for the combinational ALU and strobes the result and flag registers. It sits between the user/test front end and the D-flip-flop register bank (`fliflopD_Regis`), and is the only block that generates load enables for that bank.

---
 rtl/controle_sequenciador_ula_pkg.sv | 31 +++
 rtl/controle_sequenciador_ula_contador_exec.sv | 33 +++
 rtl/controle_sequenciador_ula.sv | 144 ++++++++++++++
 tb/tb_controle_sequenciador_ula.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_sequenciador_ula_pkg.sv
// Shared types and constants for the ALU register-datapath sequencer.
package ula_pkg;

  // Datapath and control widths
  localparam int LARGURA_DADO = 8;
  localparam int LARGURA_OPCODE = 3;
  localparam int LARGURA_CONT = 4;

  // Opcodes understood by the ALU; only NOT takes a single operand
  localparam logic [LARGURA_OPCODE-1:0] OP_SOMA = 3'b000;
  localparam logic [LARGURA_OPCODE-1:0] OP_SUB = 3'b001;
  localparam logic [LARGURA_OPCODE-1:0] OP_AND = 3'b010;
  localparam logic [LARGURA_OPCODE-1:0] OP_OR = 3'b011;
  localparam logic [LARGURA_OPCODE-1:0] OP_XOR = 3'b100;
  localparam logic [LARGURA_OPCODE-1:0] OP_SHL = 3'b101;
  localparam logic [LARGURA_OPCODE-1:0] OP_SHR = 3'b110;
  localparam logic [LARGURA_OPCODE-1:0] OP_UNARIO = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    OCIOSO,
    RECEBE_A,
    ESCRITA_A,
    RECEBE_B,
    ESCRITA_B,
    EXECUTA,
    GRAVA,
    CONCLUI
  } estado_seq_t;

endpackage

// File: rtl/controle_sequenciador_ula_contador_exec.sv
// Small loadable up/down counter with a terminal-count flag, used to time
// the ALU settle window.
module contador_exec #(
  parameter int LARGURA_CONT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    carga,
  input  logic [LARGURA_CONT-1:0] valor_carga,
  input  logic                    habilita,
  input  logic                    decrementa,
  input  logic [LARGURA_CONT-1:0] limite,
  output logic                    terminal
);

  localparam logic [LARGURA_CONT-1:0] UM = 1;

  logic [LARGURA_CONT-1:0] contagem;

  // Load has priority over counting; counting direction chosen by decrementa
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor_carga;
    end else if (habilita) begin
      contagem <= decrementa ? (contagem - UM) : (contagem + UM);
    end
  end

  assign terminal = (contagem == limite);

endmodule

// File: rtl/controle_sequenciador_ula.sv
// Sequencer that collects ALU operands over a valid/ready handshake, strobes
// them into the A/B registers, waits for the ALU to settle and then strobes
// the result and flag registers.
module controle_sequenciador_ula #(
  parameter int LARGURA = 8,
  parameter int LARGURA_OP = 3,
  parameter int CICLOS_EXEC = 1,
  parameter logic [LARGURA_OP-1:0] OP_UNARIO = ula_pkg::OP_UNARIO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inicio,
  input  logic                  abortar,
  input  logic [LARGURA_OP-1:0] opcode,
  input  logic                  dado_valido,
  input  logic [LARGURA-1:0]    dado,
  output logic                  dado_pronto,
  output logic [LARGURA-1:0]    barramento,
  output logic                  carga_a,
  output logic                  carga_b,
  output logic [LARGURA_OP-1:0] op_reg,
  output logic                  carga_res,
  output logic                  carga_flags,
  output logic                  ocupado,
  output logic                  concluido
);

  import ula_pkg::*;

  // Settle window ends when the counter reaches CICLOS_EXEC-1
  localparam logic [LARGURA_CONT-1:0] LIMITE = LARGURA_CONT'(CICLOS_EXEC - 1);

  estado_seq_t estado;
  estado_seq_t estado_prox;
  logic        captura_op;
  logic        captura_dado;
  logic        fim_exec;

  // Counter is held at zero outside EXECUTA so it always starts from 0
  contador_exec #(
    .LARGURA_CONT (LARGURA_CONT)
  ) u_contador (
    .clk         (clk),
    .reset_n     (reset_n),
    .carga       (estado != EXECUTA),
    .valor_carga ('0),
    .habilita    (1'b1),
    .decrementa  (1'b0),
    .limite      (LIMITE),
    .terminal    (fim_exec)
  );

  // State register plus the captured opcode and operand bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      barramento <= '0;
      op_reg     <= '0;
    end else begin
      estado <= estado_prox;
      if (captura_op) begin
        op_reg <= opcode;
      end
      if (captura_dado) begin
        barramento <= dado;
      end
    end
  end

  // Next-state logic and Moore output decode; abort wins over any handshake
  always_comb begin
    estado_prox  = estado;
    captura_op   = 1'b0;
    captura_dado = 1'b0;
    dado_pronto  = 1'b0;
    carga_a      = 1'b0;
    carga_b      = 1'b0;
    carga_res    = 1'b0;
    carga_flags  = 1'b0;
    concluido    = 1'b0;
    ocupado      = (estado != OCIOSO);

    case (estado)
      OCIOSO: begin
        if (inicio && !abortar) begin
          captura_op  = 1'b1;
          estado_prox = RECEBE_A;
        end
      end
      RECEBE_A: begin
        dado_pronto = 1'b1;
        if (abortar) begin
          estado_prox = OCIOSO;
        end else if (dado_valido) begin
          captura_dado = 1'b1;
          estado_prox  = ESCRITA_A;
        end
      end
      ESCRITA_A: begin
        carga_a = 1'b1;
        if (abortar) begin
          estado_prox = OCIOSO;
        end else if (op_reg == OP_UNARIO) begin
          estado_prox = EXECUTA;
        end else begin
          estado_prox = RECEBE_B;
        end
      end
      RECEBE_B: begin
        dado_pronto = 1'b1;
        if (abortar) begin
          estado_prox = OCIOSO;
        end else if (dado_valido) begin
          captura_dado = 1'b1;
          estado_prox  = ESCRITA_B;
        end
      end
      ESCRITA_B: begin
        carga_b     = 1'b1;
        estado_prox = abortar ? OCIOSO : EXECUTA;
      end
      EXECUTA: begin
        if (abortar) begin
          estado_prox = OCIOSO;
        end else if (fim_exec) begin
          estado_prox = GRAVA;
        end
      end
      GRAVA: begin
        carga_res   = 1'b1;
        carga_flags = 1'b1;
        estado_prox = abortar ? OCIOSO : CONCLUI;
      end
      CONCLUI: begin
        concluido   = 1'b1;
        estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_sequenciador_ula.sv
// Self-checking bench: two sequencer instances (settle time 1 and 15) share
// the same stimulus and are compared every cycle against a transaction-level
// reference model, plus a vector table and directed corner-case sequences.
module tb_controle_sequenciador_ula;

  import ula_pkg::*;

  typedef struct packed {
    logic       dado_pronto;
    logic [7:0] barramento;
    logic       carga_a;
    logic       carga_b;
    logic [2:0] op_reg;
    logic       carga_res;
    logic       carga_flags;
    logic       ocupado;
    logic       concluido;
  } saidas_t;

  typedef struct {
    logic       inicio;
    logic       abortar;
    logic [2:0] opcode;
    logic       dado_valido;
    logic [7:0] dado;
    saidas_t    esperado;
  } vetor_t;

  // Upcoming-cycle activities in the model's plan
  localparam int K_CARGA_A = 1;
  localparam int K_CARGA_B = 2;
  localparam int K_EXEC = 3;
  localparam int K_GRAVA = 4;
  localparam int K_FIM = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inicio;
  logic       abortar;
  logic [2:0] opcode;
  logic       dado_valido;
  logic [7:0] dado;

  logic       p1, a1, b1, r1, f1, o1, c1;
  logic [7:0] bus1;
  logic [2:0] op1;
  logic       p15, a15, b15, r15, f15, o15, c15;
  logic [7:0] bus15;
  logic [2:0] op15;

  saidas_t s1;
  saidas_t s15;

  int vetores = 0;
  int erros = 0;

  // Reference model state, index 0 = settle 1, index 1 = settle 15
  int         ciclos [2] = '{1, 15};
  bit         m_ativo [2];
  int         m_total [2];
  int         m_aceitos [2];
  logic [7:0] m_bus [2];
  logic [2:0] m_op [2];
  int         plano [2][0:31];
  int         pos [2];
  int         len [2];

  vetor_t tabela [14];

  always #5 clk = ~clk;

  controle_sequenciador_ula #(
    .LARGURA (8), .LARGURA_OP (3), .CICLOS_EXEC (1), .OP_UNARIO (3'b111)
  ) dut1 (
    .clk (clk), .reset_n (reset_n), .inicio (inicio), .abortar (abortar),
    .opcode (opcode), .dado_valido (dado_valido), .dado (dado),
    .dado_pronto (p1), .barramento (bus1), .carga_a (a1), .carga_b (b1),
    .op_reg (op1), .carga_res (r1), .carga_flags (f1), .ocupado (o1),
    .concluido (c1)
  );

  controle_sequenciador_ula #(
    .LARGURA (8), .LARGURA_OP (3), .CICLOS_EXEC (15), .OP_UNARIO (3'b111)
  ) dut15 (
    .clk (clk), .reset_n (reset_n), .inicio (inicio), .abortar (abortar),
    .opcode (opcode), .dado_valido (dado_valido), .dado (dado),
    .dado_pronto (p15), .barramento (bus15), .carga_a (a15), .carga_b (b15),
    .op_reg (op15), .carga_res (r15), .carga_flags (f15), .ocupado (o15),
    .concluido (c15)
  );

  assign s1 = {p1, bus1, a1, b1, op1, r1, f1, o1, c1};
  assign s15 = {p15, bus15, a15, b15, op15, r15, f15, o15, c15};

  function automatic saidas_t sai(logic pr, logic [7:0] bus, logic ca, logic cb,
                                  logic [2:0] op, logic cr, logic cf, logic oc,
                                  logic co);
    saidas_t s;
    s = {pr, bus, ca, cb, op, cr, cf, oc, co};
    return s;
  endfunction

  task automatic comparar(string nome, logic [31:0] atual, logic [31:0] esperado);
    vetores++;
    if (atual !== esperado) begin
      erros++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic modelo_reset();
    for (int m = 0; m < 2; m++) begin
      m_ativo[m] = 1'b0;
      m_total[m] = 0;
      m_aceitos[m] = 0;
      m_bus[m] = 8'h00;
      m_op[m] = 3'b000;
      pos[m] = 0;
      len[m] = 0;
    end
  endtask

  task automatic agendar(int m, int k);
    plano[m][len[m]] = k;
    len[m]++;
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic modelo_borda(int m);
    if (!m_ativo[m]) begin
      if (inicio && !abortar) begin
        m_ativo[m] = 1'b1;
        m_op[m] = opcode;
        m_total[m] = (opcode == OP_UNARIO) ? 1 : 2;
        m_aceitos[m] = 0;
        pos[m] = 0;
        len[m] = 0;
      end
    end else if (abortar) begin
      m_ativo[m] = 1'b0;
      pos[m] = 0;
      len[m] = 0;
    end else if (pos[m] < len[m]) begin
      pos[m]++;
      if (pos[m] == len[m]) begin
        pos[m] = 0;
        len[m] = 0;
        if (m_aceitos[m] == m_total[m]) m_ativo[m] = 1'b0;
      end
    end else if (dado_valido) begin
      m_bus[m] = dado;
      agendar(m, (m_aceitos[m] == 0) ? K_CARGA_A : K_CARGA_B);
      m_aceitos[m]++;
      if (m_aceitos[m] == m_total[m]) begin
        for (int i = 0; i < ciclos[m]; i++) agendar(m, K_EXEC);
        agendar(m, K_GRAVA);
        agendar(m, K_FIM);
      end
    end
  endtask

  function automatic saidas_t modelo_saida(int m);
    saidas_t s;
    s = '0;
    s.barramento = m_bus[m];
    s.op_reg = m_op[m];
    if (m_ativo[m]) begin
      s.ocupado = 1'b1;
      if (pos[m] < len[m]) begin
        case (plano[m][pos[m]])
          K_CARGA_A: s.carga_a = 1'b1;
          K_CARGA_B: s.carga_b = 1'b1;
          K_GRAVA: begin
            s.carga_res = 1'b1;
            s.carga_flags = 1'b1;
          end
          K_FIM: s.concluido = 1'b1;
          default: ;
        endcase
      end else begin
        s.dado_pronto = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic apply_stimulus(logic ini, logic abt, logic [2:0] op, logic dv, logic [7:0] d);
    inicio = ini;
    abortar = abt;
    opcode = op;
    dado_valido = dv;
    dado = d;
  endtask

  task automatic check_output();
    comparar("model_settle1", 32'(s1), 32'(modelo_saida(0)));
    comparar("model_settle15", 32'(s15), 32'(modelo_saida(1)));
  endtask

  task automatic tick();
    @(posedge clk);
    modelo_borda(0);
    modelo_borda(1);
    #1;
    check_output();
  endtask

  // Asynchronous reset pulse placed mid-cycle
  task automatic reset_duts();
    apply_stimulus(1'b0, 1'b0, 3'b000, 1'b0, 8'h00);
    reset_n = 1'b0;
    #2;
    modelo_reset();
    check_output();
    comparar("reset_outputs_s1", 32'(s1), 32'(sai(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0)));
    comparar("reset_outputs_s15", 32'(s15), 32'(sai(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0)));
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int fim1;
    int fim15;
    int n_exec;

    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 3'b000, 1'b0, 8'h00);
    modelo_reset();
    #3;
    reset_duts();

    // Binary op 3C/A5 then unary F0, settle 1, valid always high
    tabela[0]  = '{1, 0, 3'b000, 1, 8'h3C, sai(1, 8'h00, 0, 0, 3'b000, 0, 0, 1, 0)};
    tabela[1]  = '{0, 0, 3'b000, 1, 8'h3C, sai(0, 8'h3C, 1, 0, 3'b000, 0, 0, 1, 0)};
    tabela[2]  = '{0, 0, 3'b000, 1, 8'hA5, sai(1, 8'h3C, 0, 0, 3'b000, 0, 0, 1, 0)};
    tabela[3]  = '{0, 0, 3'b000, 1, 8'hA5, sai(0, 8'hA5, 0, 1, 3'b000, 0, 0, 1, 0)};
    tabela[4]  = '{0, 0, 3'b000, 1, 8'hA5, sai(0, 8'hA5, 0, 0, 3'b000, 0, 0, 1, 0)};
    tabela[5]  = '{0, 0, 3'b000, 1, 8'hA5, sai(0, 8'hA5, 0, 0, 3'b000, 1, 1, 1, 0)};
    tabela[6]  = '{0, 0, 3'b000, 1, 8'hA5, sai(0, 8'hA5, 0, 0, 3'b000, 0, 0, 1, 1)};
    tabela[7]  = '{0, 0, 3'b000, 1, 8'hA5, sai(0, 8'hA5, 0, 0, 3'b000, 0, 0, 0, 0)};
    tabela[8]  = '{1, 0, 3'b111, 1, 8'hF0, sai(1, 8'hA5, 0, 0, 3'b111, 0, 0, 1, 0)};
    tabela[9]  = '{0, 0, 3'b111, 1, 8'hF0, sai(0, 8'hF0, 1, 0, 3'b111, 0, 0, 1, 0)};
    tabela[10] = '{0, 0, 3'b111, 1, 8'hF0, sai(0, 8'hF0, 0, 0, 3'b111, 0, 0, 1, 0)};
    tabela[11] = '{0, 0, 3'b111, 1, 8'hF0, sai(0, 8'hF0, 0, 0, 3'b111, 1, 1, 1, 0)};
    tabela[12] = '{0, 0, 3'b111, 1, 8'hF0, sai(0, 8'hF0, 0, 0, 3'b111, 0, 0, 1, 1)};
    tabela[13] = '{0, 0, 3'b111, 1, 8'hF0, sai(0, 8'hF0, 0, 0, 3'b111, 0, 0, 0, 0)};

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(tabela[i].inicio, tabela[i].abortar, tabela[i].opcode,
                     tabela[i].dado_valido, tabela[i].dado);
      tick();
      comparar($sformatf("table_%0d", i), 32'(s1), 32'(tabela[i].esperado));
    end

    // Reset in the middle of the long settle window, then a fresh run
    $display("[TB] reset during settle");
    reset_duts();
    apply_stimulus(1'b1, 1'b0, 3'b000, 1'b1, 8'hC3);
    tick();
    for (int e = 1; e <= 5; e++) begin
      apply_stimulus(1'b0, 1'b0, 3'b000, 1'b1, 8'hC3);
      tick();
    end
    comparar("settle15_busy_before_reset", 32'(s15.ocupado), 32'(1));
    reset_duts();
    apply_stimulus(1'b1, 1'b0, 3'b000, 1'b1, 8'h66);
    tick();
    fim1 = -1;
    fim15 = -1;
    for (int e = 1; e <= 40 && fim15 < 0; e++) begin
      apply_stimulus(1'b0, 1'b0, 3'b000, 1'b1, 8'h66);
      tick();
      if (s1.concluido && fim1 < 0) fim1 = e;
      if (s15.concluido && fim15 < 0) fim15 = e;
    end
    comparar("latency_binary_settle1", 32'(fim1), 32'(6));
    comparar("latency_binary_settle15", 32'(fim15), 32'(20));

    // Requester stalls five cycles while operand B is awaited
    $display("[TB] stall in operand B");
    reset_duts();
    apply_stimulus(1'b1, 1'b0, 3'b001, 1'b1, 8'h11);
    tick();
    fim1 = -1;
    for (int e = 1; e <= 40 && fim1 < 0; e++) begin
      apply_stimulus(1'b0, 1'b0, 3'b001, (e == 1 || e >= 8), 8'h22);
      tick();
      if (e >= 2 && e <= 7) begin
        comparar($sformatf("stall_ready_%0d", e), 32'({s1.dado_pronto, s1.ocupado}), 32'(2'b11));
        comparar($sformatf("stall_strobes_%0d", e),
                 32'({s1.carga_a, s1.carga_b, s1.carga_res, s1.carga_flags, s1.concluido}), 32'(0));
      end
      if (s1.concluido) fim1 = e;
    end
    comparar("stall_latency", 32'(fim1), 32'(11));

    // Abort coinciding with an operand handshake
    $display("[TB] abort with handshake");
    reset_duts();
    apply_stimulus(1'b1, 1'b0, 3'b010, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b1, 3'b010, 1'b1, 8'h5A);
    tick();
    comparar("abort_idle", 32'(s1), 32'(sai(0, 8'h00, 0, 0, 3'b010, 0, 0, 0, 0)));
    for (int e = 0; e < 8; e++) begin
      apply_stimulus(1'b0, 1'b0, 3'b010, 1'b1, 8'h5A);
      tick();
      comparar($sformatf("abort_quiet_%0d", e), 32'({s1.carga_a, s1.concluido, s1.ocupado}), 32'(0));
    end

    // Start pulse during settle is ignored; pulse right after completion is taken
    $display("[TB] start pulses around long settle");
    reset_duts();
    apply_stimulus(1'b1, 1'b0, 3'b001, 1'b1, 8'h44);
    tick();
    fim15 = -1;
    n_exec = 0;
    for (int e = 1; e <= 22; e++) begin
      apply_stimulus((e == 10 || e == 22), 1'b0, 3'b001, 1'b1, 8'h44);
      tick();
      if (e <= 21 && s15.ocupado && !s15.dado_pronto && !s15.carga_a && !s15.carga_b
          && !s15.carga_res && !s15.concluido) n_exec++;
      if (s15.concluido && fim15 < 0) fim15 = e;
    end
    comparar("settle15_exec_cycles", 32'(n_exec), 32'(15));
    comparar("settle15_done_edge", 32'(fim15), 32'(20));
    comparar("restart_after_done", 32'({s15.dado_pronto, s15.ocupado}), 32'(2'b11));

    // Randomized traffic against the model
    $display("[TB] random traffic");
    reset_duts();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_duts();
      end else begin
        apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
